spi_slave_rram: RTL and testbench
=================================

Name: spi_slave_rram

Overview:
SPI slave (mode 0, MSB first) that gives an external master access to the RRAM controller.
- Master reads/writes a bank of configuration words that drive the RRAM FSM (fsm_bits).
- Master reads back diagnostic and RRAM read-data words.
- Master issues a "go" command that raises fsm_go to start the FSM.
- Sits between chip pads (sclk/sc/mosi/miso) and the RRAM controller FSM.

Parameters:
NUM_CFG_WORDS, 8, number of 32-bit read/write configuration words; fsm_bits width = 32*NUM_CFG_WORDS.
DIAG_W, 32, width of diag_bits (≤32).
READ_W, 48, width of read_data_bits (≤64).
RANGE_W, 4, width of rangei.

Ports:
sclk  input  1  SPI serial clock; the block's only clock.
rst_n  input  1  chip reset; asynchronous, active-low; clears everything.
sc  input  1  chip select, active-high; sc=0 asynchronously resets the frame logic only.
mosi  input  1  serial data in, sampled on sclk rising edge.
miso  output  1  serial data out, updated on sclk falling edge.
miso_oe_n  output  1  miso output enable, active-low.
fsm_go  output  1  FSM start request.
fsm_bits  output  32*NUM_CFG_WORDS  config register contents; word k occupies bits [32k+31:32k].
diag_bits  input  DIAG_W  FSM diagnostic status.
read_data_bits  input  READ_W  RRAM read data.
rangei  output  RANGE_W  range index; equals fsm_bits[RANGE_W-1:0].

Behaviour:
- Reset (rst_n=0, async):
  - fsm_bits=0, fsm_go=0, miso=0, miso_oe_n=1.
  - Bit counter, command and shift registers cleared.
- sc=0 (async):
  - Clears bit counter, command and shift registers.
  - fsm_go=0, miso_oe_n=1, miso=0.
  - fsm_bits retained.
- Frame format, counted in rising sclk edges while sc=1:
  - Bits 1-8: header {cmd[1:0], addr[5:0]}, MSB first.
  - Bits 9-40: 32-bit data phase.
- cmd=01 write:
  - Shift 32 mosi bits.
  - On the 40th rising edge, commit to config word addr if addr < NUM_CFG_WORDS; otherwise discard.
- cmd=00 read: on the 8th rising edge, load a 32-bit output shift register from the address map:
  - addr 0..NUM_CFG_WORDS-1: config word.
  - 0x10: read_data_bits[31:0].
  - 0x11: read_data_bits[READ_W-1:32], zero-extended.
  - 0x18: diag_bits, zero-extended.
  - Any other address: 0.
  - Read output timing:
    - miso_oe_n goes low on the falling edge after the 8th rising edge and stays low through the 40th bit.
    - Data MSB is driven at that same falling edge; one new bit per falling edge.
    - Sampled input values are captured at header end, so later input changes do not affect the word in flight.
- cmd=10 go:
  - On the 8th rising edge set fsm_go=1 (addr ignored).
  - Held until sc=0 or rst_n=0.
  - The downstream FSM synchronizes fsm_go itself.
- cmd=11: reserved; frame ignored, no outputs change.
- Frame boundaries:
  - After bit 40, further edges are ignored until sc drops: no second frame without sc toggling; miso_oe_n returns high after the 40th bit's falling edge.
  - A partial write (sc drops before bit 40) leaves registers unchanged.
  - A partial read has no side effects.
- miso_oe_n is high whenever no read data phase is active, including during headers, write and go frames.
- Write-then-read of the same word in separate frames returns the written value; fsm_bits updates exactly at the commit edge.

Test Plan:
- Reset: pulse rst_n low -> fsm_bits=0, fsm_go=0, miso_oe_n=1, rangei=0.
- Write/read-back:
  - Write 0xDEADBEEF to addr 3 -> fsm_bits[127:96]=0xDEADBEEF after edge 40.
  - Reading addr 3 then shifts 0xDEADBEEF out MSB-first with miso_oe_n=0 for exactly 32 bits.
- rangei: write 0x0000000A to addr 0 -> rangei=4'hA.
- Status reads:
  - read_data_bits=48'h123456789ABC: addr 0x10 returns 0x56789ABC; addr 0x11 returns 0x00001234.
  - diag_bits=0xCAFE0001: addr 0x18 returns 0xCAFE0001.
- Go: send header 0x80 -> fsm_go=1 after 8th edge; drop sc -> fsm_go=0 asynchronously; fsm_bits unchanged.
- Aborted write: write to addr 1 with sc dropped after 20 bits -> word 1 unchanged.
- Out-of-range accesses:
  - Write to addr 0x3F -> no change.
  - Read of 0x3F -> 0x00000000.
- Mid-frame reset: rst_n low mid-frame -> all outputs return to reset values.

Source files
------------

// File: rtl/spi_slave_rram_if.sv
// rtl/spi_slave_rram_if.sv - SPI pad bundle between an external master and the RRAM SPI slave
//
// Purpose: groups the chip-select and data pads of the SPI link; sclk and
// rst_n stay as plain ports on the modules that use them.
// Signals:
//   sc        chip select, active-high (master -> slave)
//   mosi      serial data, master -> slave
//   miso      serial data, slave -> master
//   miso_oe_n miso pad output enable, active-low (slave -> pad)
interface spi_slave_rram_if;
  logic sc;
  logic mosi;
  logic miso;
  logic miso_oe_n;

  modport master (output sc, output mosi, input miso, input miso_oe_n);
  modport slave  (input sc, input mosi, output miso, output miso_oe_n);
endinterface

// File: rtl/spi_slave_rram.sv
// rtl/spi_slave_rram.sv - SPI mode-0 slave giving an external master access to RRAM controller config/status
//
// Purpose: 40-bit frames {cmd[1:0], addr[5:0], data[31:0]}, MSB first.
//   cmd 01 writes config word addr, cmd 00 reads the address map,
//   cmd 10 raises fsm_go until sc drops, cmd 11 is ignored.
// Ports:
//   sclk           SPI clock, the only clock
//   rst_n          async active-low chip reset, clears everything
//   spi            pad bundle (sc, mosi, miso, miso_oe_n); sc=0 resets the frame logic
//   fsm_go         FSM start request
//   fsm_bits       config words, word k at [32k+31:32k]
//   diag_bits      FSM diagnostic status (readable at 0x18)
//   read_data_bits RRAM read data (readable at 0x10 / 0x11)
//   rangei         fsm_bits[RANGE_W-1:0]
module spi_slave_rram #(
  parameter int NUM_CFG_WORDS = 8,
  parameter int DIAG_W        = 32,
  parameter int READ_W        = 48,
  parameter int RANGE_W       = 4
) (
  input  logic                       sclk,
  input  logic                       rst_n,
  spi_slave_rram_if.slave            spi,
  output logic                       fsm_go,
  output logic [32*NUM_CFG_WORDS-1:0] fsm_bits,
  input  logic [DIAG_W-1:0]          diag_bits,
  input  logic [READ_W-1:0]          read_data_bits,
  output logic [RANGE_W-1:0]         rangei
);

  typedef enum logic [2:0] {
    ST_HDR,
    ST_WR,
    ST_RD,
    ST_GO,
    ST_IGN,
    ST_DONE
  } state_e;

  // Frame logic is cleared by either chip reset or chip-select deassertion.
  logic frame_rst_n;
  assign frame_rst_n = rst_n & spi.sc;

  state_e                      state_q, state_d;
  logic [5:0]                  bit_cnt_q, bit_cnt_d;
  logic [30:0]                 shift_q, shift_d;
  logic [5:0]                  addr_q, addr_d;
  logic [31:0]                 tx_q, tx_d;
  logic                        go_q, go_d;
  logic                        miso_q, miso_d;
  logic                        oe_n_q, oe_n_d;
  logic [32*NUM_CFG_WORDS-1:0] cfg_q;

  logic [7:0]  hdr_byte;
  logic [31:0] wdata;
  logic [31:0] map_word;
  logic [63:0] rd_ext;
  logic        commit;
  logic [4:0]  tx_idx;

  // Header/data as they stand once the current mosi bit is included.
  assign hdr_byte = {shift_q[6:0], spi.mosi};
  assign wdata    = {shift_q, spi.mosi};

  // Read address map, evaluated against the header address at edge 8.
  always_comb begin
    rd_ext   = 64'(read_data_bits);
    map_word = '0;
    case (hdr_byte[5:0])
      6'h10:   map_word = rd_ext[31:0];
      6'h11:   map_word = rd_ext[63:32];
      6'h18:   map_word = 32'(diag_bits);
      default: begin
        for (int k = 0; k < NUM_CFG_WORDS; k++) begin
          if (hdr_byte[5:0] == 6'(k)) map_word = cfg_q[32*k +: 32];
        end
      end
    endcase
  end

  // Next-state and rising-edge datapath.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    tx_d      = tx_q;
    go_d      = go_q;
    commit    = 1'b0;

    // Counting and shifting stop once the 40-bit frame is complete.
    if (state_q != ST_DONE) begin
      bit_cnt_d = bit_cnt_q + 6'd1;
      shift_d   = {shift_q[29:0], spi.mosi};
    end

    case (state_q)
      ST_HDR: begin
        if (bit_cnt_q == 6'd7) begin
          addr_d = hdr_byte[5:0];
          case (hdr_byte[7:6])
            2'b01: state_d = ST_WR;
            2'b00: begin
              state_d = ST_RD;
              tx_d    = map_word;
            end
            2'b10: begin
              state_d = ST_GO;
              go_d    = 1'b1;
            end
            default: state_d = ST_IGN;
          endcase
        end
      end
      ST_WR: begin
        if (bit_cnt_q == 6'd39) begin
          state_d = ST_DONE;
          commit  = 1'b1;
        end
      end
      ST_RD, ST_GO, ST_IGN: begin
        if (bit_cnt_q == 6'd39) state_d = ST_DONE;
      end
      default: state_d = ST_DONE;
    endcase
  end

  always_ff @(posedge sclk or negedge frame_rst_n) begin
    if (!frame_rst_n) begin
      state_q   <= ST_HDR;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      tx_q      <= '0;
      go_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      tx_q      <= tx_d;
      go_q      <= go_d;
    end
  end

  // Config words survive sc deassertion; only chip reset clears them.
  // Addresses at or above NUM_CFG_WORDS match no word and are dropped.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q <= '0;
    end else if (commit) begin
      for (int k = 0; k < NUM_CFG_WORDS; k++) begin
        if (addr_q == 6'(k)) cfg_q[32*k +: 32] <= wdata;
      end
    end
  end

  // Falling edge after rising edge n (8..39) presents word bit 39-n,
  // so the master samples bit 31 on rising edge 9 and bit 0 on edge 40.
  assign tx_idx = 5'(6'd39 - bit_cnt_q);

  always_comb begin
    miso_d = 1'b0;
    oe_n_d = 1'b1;
    if (state_q == ST_RD) begin
      miso_d = tx_q[tx_idx];
      oe_n_d = 1'b0;
    end
  end

  always_ff @(negedge sclk or negedge frame_rst_n) begin
    if (!frame_rst_n) begin
      miso_q <= 1'b0;
      oe_n_q <= 1'b1;
    end else begin
      miso_q <= miso_d;
      oe_n_q <= oe_n_d;
    end
  end

  assign spi.miso      = miso_q;
  assign spi.miso_oe_n = oe_n_q;
  assign fsm_go        = go_q;
  assign fsm_bits      = cfg_q;
  assign rangei        = cfg_q[RANGE_W-1:0];

endmodule

// File: tb/tb_spi_slave_rram.sv
// tb/tb_spi_slave_rram.sv - directed self-checking bench for spi_slave_rram
module tb_spi_slave_rram;

  logic         sclk;
  logic         rst_n;
  logic         fsm_go;
  logic [255:0] fsm_bits;
  logic [31:0]  diag_bits;
  logic [47:0]  read_data_bits;
  logic [3:0]   rangei;

  spi_slave_rram_if spi_if ();

  spi_slave_rram #(
    .NUM_CFG_WORDS(8),
    .DIAG_W(32),
    .READ_W(48),
    .RANGE_W(4)
  ) dut (
    .sclk(sclk),
    .rst_n(rst_n),
    .spi(spi_if),
    .fsm_go(fsm_go),
    .fsm_bits(fsm_bits),
    .diag_bits(diag_bits),
    .read_data_bits(read_data_bits),
    .rangei(rangei)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int n_cmp;
  int n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One frame of nbits rising edges; sc is left high so callers can check mid-frame state.
  // miso/oe are sampled 1 time unit after each falling edge.
  task automatic frame(input logic [7:0] hdr, input logic [31:0] data, input int nbits,
                       output logic [31:0] rd, output int oe_cnt, output logic last_oe);
    rd = '0;
    oe_cnt = 0;
    last_oe = 1'b1;
    @(negedge sclk);
    #1;
    spi_if.sc = 1'b1;
    for (int i = 1; i <= nbits; i++) begin
      if (i <= 8) spi_if.mosi = hdr[8-i];
      else if (i <= 40) spi_if.mosi = data[40-i];
      else spi_if.mosi = 1'b1;
      @(posedge sclk);
      @(negedge sclk);
      #1;
      if (i >= 8 && i <= 39) rd = {rd[30:0], spi_if.miso};
      if (!spi_if.miso_oe_n) oe_cnt++;
      last_oe = spi_if.miso_oe_n;
    end
  endtask

  task automatic end_frame();
    spi_if.sc = 1'b0;
    spi_if.mosi = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  logic [31:0]  rd;
  int           oe_cnt;
  logic         last_oe;
  logic [255:0] snap;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    spi_if.sc = 1'b0;
    spi_if.mosi = 1'b0;
    diag_bits = 32'hCAFE0001;
    read_data_bits = 48'h123456789ABC;
    #23;
    chk("rst_fsm_bits", 64'(fsm_bits == 256'h0), 64'd1);
    chk("rst_fsm_go", 64'(fsm_go), 64'd0);
    chk("rst_oe_n", 64'(spi_if.miso_oe_n), 64'd1);
    chk("rst_miso", 64'(spi_if.miso), 64'd0);
    chk("rst_rangei", 64'(rangei), 64'd0);
    rst_n = 1'b1;
    #10;

    // Write 0xDEADBEEF to word 3.
    frame(8'h43, 32'hDEADBEEF, 40, rd, oe_cnt, last_oe);
    chk("wr3_word", 64'(fsm_bits[127:96]), 64'hDEADBEEF);
    chk("wr3_others", 64'(fsm_bits[95:0] == 96'h0 && fsm_bits[255:128] == 128'h0), 64'd1);
    chk("wr3_oe_cnt", 64'(oe_cnt), 64'd0);
    chk("wr3_go", 64'(fsm_go), 64'd0);
    end_frame();

    // Read word 3, with 8 extra edges that must be ignored.
    frame(8'h03, 32'h0, 48, rd, oe_cnt, last_oe);
    chk("rd3_data", 64'(rd), 64'hDEADBEEF);
    chk("rd3_oe_cnt", 64'(oe_cnt), 64'd32);
    chk("rd3_oe_end", 64'(last_oe), 64'd1);
    end_frame();
    chk("rd3_no_side", 64'(fsm_bits[127:96]), 64'hDEADBEEF);

    // rangei follows word 0.
    frame(8'h40, 32'h0000000A, 40, rd, oe_cnt, last_oe);
    end_frame();
    chk("rangei", 64'(rangei), 64'hA);
    chk("wr0_word", 64'(fsm_bits[31:0]), 64'h0000000A);

    // Status reads.
    frame(8'h10, 32'h0, 40, rd, oe_cnt, last_oe);
    end_frame();
    chk("rd_0x10", 64'(rd), 64'h56789ABC);
    frame(8'h11, 32'h0, 40, rd, oe_cnt, last_oe);
    end_frame();
    chk("rd_0x11", 64'(rd), 64'h00001234);
    frame(8'h18, 32'h0, 40, rd, oe_cnt, last_oe);
    end_frame();
    chk("rd_0x18", 64'(rd), 64'hCAFE0001);
    chk("rd_0x18_oe_cnt", 64'(oe_cnt), 64'd32);

    // Go: not yet after 7 edges, set after 8, cleared asynchronously by sc.
    snap = fsm_bits;
    frame(8'h80, 32'h0, 7, rd, oe_cnt, last_oe);
    chk("go_7_edges", 64'(fsm_go), 64'd0);
    end_frame();
    frame(8'h80, 32'h0, 8, rd, oe_cnt, last_oe);
    chk("go_set", 64'(fsm_go), 64'd1);
    chk("go_oe", 64'(spi_if.miso_oe_n), 64'd1);
    end_frame();
    chk("go_clr", 64'(fsm_go), 64'd0);
    chk("go_cfg_kept", 64'(fsm_bits == snap), 64'd1);

    // Aborted write to word 1.
    frame(8'h41, 32'h11112222, 20, rd, oe_cnt, last_oe);
    end_frame();
    chk("abort_wr1", 64'(fsm_bits[63:32]), 64'h0);

    // Out-of-range write and read.
    snap = fsm_bits;
    frame(8'h7F, 32'hFFFFFFFF, 40, rd, oe_cnt, last_oe);
    end_frame();
    chk("wr_oor", 64'(fsm_bits == snap), 64'd1);
    frame(8'h3F, 32'h0, 40, rd, oe_cnt, last_oe);
    end_frame();
    chk("rd_oor", 64'(rd), 64'h0);
    chk("rd_oor_oe_cnt", 64'(oe_cnt), 64'd32);

    // Reserved command changes nothing.
    frame(8'hC3, 32'h12345678, 40, rd, oe_cnt, last_oe);
    chk("rsv_go", 64'(fsm_go), 64'd0);
    chk("rsv_oe_cnt", 64'(oe_cnt), 64'd0);
    end_frame();
    chk("rsv_cfg", 64'(fsm_bits == snap), 64'd1);

    // Trailing edges after bit 40 must not disturb a committed write.
    frame(8'h45, 32'h0F0F0F0F, 48, rd, oe_cnt, last_oe);
    end_frame();
    chk("wr5_long", 64'(fsm_bits[191:160]), 64'h0F0F0F0F);

    // Read-data input captured at header end.
    frame(8'h10, 32'h0, 20, rd, oe_cnt, last_oe);
    read_data_bits = 48'h0;
    frame_rest: begin
      for (int i = 21; i <= 40; i++) begin
        spi_if.mosi = 1'b0;
        @(posedge sclk);
        @(negedge sclk);
        #1;
        if (i <= 39) rd = {rd[30:0], spi_if.miso};
      end
    end
    end_frame();
    chk("rd_capture", 64'(rd), 64'h56789ABC);
    read_data_bits = 48'h123456789ABC;

    // Mid-frame reset during a read data phase.
    frame(8'h03, 32'h0, 20, rd, oe_cnt, last_oe);
    chk("mid_oe_active", 64'(last_oe), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_oe", 64'(spi_if.miso_oe_n), 64'd1);
    chk("mid_rst_miso", 64'(spi_if.miso), 64'd0);
    chk("mid_rst_cfg", 64'(fsm_bits == 256'h0), 64'd1);
    chk("mid_rst_rangei", 64'(rangei), 64'd0);
    rst_n = 1'b1;
    end_frame();

    // Mid-frame reset while go is held.
    frame(8'h80, 32'h0, 12, rd, oe_cnt, last_oe);
    chk("go_before_rst", 64'(fsm_go), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("go_after_rst", 64'(fsm_go), 64'd0);
    rst_n = 1'b1;
    end_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
